// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped blocking instruction cache with handshaked line refill
// Hits answer combinationally; a miss stalls the core while an FSM fetches the line one word per ack.
module icache_dm #(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stallreq_o,
    input  logic        invalidate_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [0:0] {
        S_IDLE,
        S_REFILL
    } state_t;

    state_t             state_q;
    logic [OFF_W-1:0]   beat_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [IDX_W-1:0]   miss_idx_q;
    logic               poison_q;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   valid_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES*LINE_WORDS];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic               hit;
    logic               last_beat;
    logic               beat_ack;
    logic               refill_done;
    logic [OFF_W-1:0]   beat_next;
    logic [1:0]         unused_addr_bits;

    assign req_off = rom_addr_i[OFF_W+1:2];
    assign req_idx = rom_addr_i[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag = rom_addr_i[31:32-TAG_W];
    assign unused_addr_bits = rom_addr_i[1:0];

    assign hit        = rom_ce_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);
    assign rom_data_o = hit ? data_mem[{req_idx, req_off}] : 32'h0;
    assign stallreq_o = rom_ce_i & ~hit;

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    assign last_beat   = (beat_q == OFF_W'(LINE_WORDS - 1));
    assign beat_ack    = (state_q == S_REFILL) & mem_ack_i;
    assign refill_done = beat_ack & last_beat;
    assign beat_next   = beat_q + OFF_W'(1);

    // Invalidate wins over a completing refill so a poisoned line never becomes valid.
    always_comb begin
        valid_d = valid_q;
        if (invalidate_i) begin
            valid_d = '0;
        end else if (refill_done && !poison_q) begin
            valid_d[miss_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            poison_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            valid_q    <= '0;
        end else begin
            valid_q <= valid_d;
            case (state_q)
                S_IDLE: begin
                    if (rom_ce_i && !hit) begin
                        state_q    <= S_REFILL;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        beat_q     <= '0;
                        poison_q   <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
                S_REFILL: begin
                    if (invalidate_i) begin
                        poison_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        if (last_beat) begin
                            state_q    <= S_IDLE;
                            beat_q     <= '0;
                            poison_q   <= 1'b0;
                            mem_req_q  <= 1'b0;
                            mem_addr_q <= 32'h0;
                        end else begin
                            beat_q     <= beat_next;
                            mem_addr_q <= {miss_tag_q, miss_idx_q, beat_next, 2'b00};
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Array contents are not reset; valid_q alone decides whether they are visible.
    always_ff @(posedge clk) begin
        if (beat_ack) begin
            data_mem[{miss_idx_q, beat_q}] <= mem_data_i;
            if (last_beat) begin
                tag_mem[miss_idx_q] <= miss_tag_q;
            end
        end
    end

endmodule
